// File: rtl/fetch_control_pkg.sv
// Shared LC-3b fetch types: the PC mux select encoding and the fetch
// controller state encoding.
package fetch_control_pkg;

  typedef enum logic [1:0] {
    pcmux_pc_plus2 = 2'b00,
    pcmux_br       = 2'b01,
    pcmux_sr1      = 2'b10,
    pcmux_mdr      = 2'b11
  } lc3b_pcmux_sel;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    HOLD      = 2'b01,
    TRAP_WAIT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_control.sv
// LC-3b instruction-fetch sequencer: PC load/mux control, imem read strobe,
// stall absorption, redirect latching (oldest wins) and wrong-path squash.
module fetch_control
  import fetch_control_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_resp,
  input  logic          stall,
  input  logic          redirect_req,
  input  lc3b_pcmux_sel redirect_kind,
  input  logic          trap_vec_valid,
  output logic          load_pc,
  output lc3b_pcmux_sel pcmux_sel,
  output logic          imem_read,
  output logic          ir_load,
  output logic          if_valid,
  output logic          flush
);

  fetch_state_e  state_q, state_d;
  logic          pend_v_q, pend_v_d;
  lc3b_pcmux_sel pend_kind_q, pend_kind_d;

  logic          accept;
  logic          erv;
  logic          consume;
  lc3b_pcmux_sel ekind;

  // Redirect arbitration: a pending redirect always outranks a new request.
  always_comb begin
    accept = redirect_req && (redirect_kind != pcmux_pc_plus2) && !pend_v_q &&
             (state_q != TRAP_WAIT) && !reset;
    erv    = pend_v_q || accept;
    ekind  = pend_v_q ? pend_kind_q : redirect_kind;
    case (state_q)
      FETCH:   consume = imem_resp && erv;
      HOLD:    consume = erv;
      default: consume = 1'b0;
    endcase
  end

  // State and redirect-pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pend_v_q    <= 1'b0;
      pend_kind_q <= pcmux_pc_plus2;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_kind_q <= pend_kind_d;
    end
  end

  // Next-state and pending-latch update.
  always_comb begin
    state_d     = state_q;
    pend_v_d    = pend_v_q;
    pend_kind_d = pend_kind_q;
    case (state_q)
      FETCH: begin
        if (imem_resp && erv) begin
          state_d = (ekind == pcmux_mdr) ? TRAP_WAIT : FETCH;
        end else if (imem_resp && stall) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (erv) begin
          state_d = (ekind == pcmux_mdr) ? TRAP_WAIT : FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      TRAP_WAIT: begin
        if (trap_vec_valid) begin
          state_d = FETCH;
        end else begin
          state_d = TRAP_WAIT;
        end
      end
      default: state_d = FETCH;
    endcase
    if (consume) begin
      pend_v_d = 1'b0;
    end else if (accept) begin
      pend_v_d    = 1'b1;
      pend_kind_d = redirect_kind;
    end else begin
      pend_v_d = pend_v_q;
    end
  end

  // Mealy outputs; everything is held low during reset.
  always_comb begin
    load_pc   = 1'b0;
    pcmux_sel = pcmux_pc_plus2;
    imem_read = 1'b0;
    ir_load   = 1'b0;
    if_valid  = 1'b0;
    flush     = accept;
    if (reset) begin
      flush = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          imem_read = 1'b1;
          if (imem_resp && erv) begin
            if (ekind != pcmux_mdr) begin
              load_pc   = 1'b1;
              pcmux_sel = ekind;
            end else begin
              load_pc = 1'b0;
            end
          end else if (imem_resp) begin
            ir_load  = 1'b1;
            if_valid = 1'b1;
            load_pc  = !stall;
          end else begin
            load_pc = 1'b0;
          end
        end
        HOLD: begin
          if_valid = !erv;
          if (erv && (ekind != pcmux_mdr)) begin
            load_pc   = 1'b1;
            pcmux_sel = ekind;
          end else if (!erv && !stall) begin
            load_pc = 1'b1;
          end else begin
            load_pc = 1'b0;
          end
        end
        TRAP_WAIT: begin
          if (trap_vec_valid) begin
            load_pc   = 1'b1;
            pcmux_sel = pcmux_mdr;
          end else begin
            load_pc = 1'b0;
          end
        end
        default: begin
          load_pc = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed scenarios plus random
// traffic, checked against a flag-based fetch model and a modelled PC register.
module tb_fetch_control;
  import fetch_control_pkg::*;

  logic          clk = 1'b0;
  logic          reset, imem_resp, stall, redirect_req, trap_vec_valid;
  lc3b_pcmux_sel redirect_kind, pcmux_sel;
  logic          load_pc, imem_read, ir_load, if_valid, flush;

  always #5 clk = ~clk;

  fetch_control dut (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .stall(stall),
    .redirect_req(redirect_req), .redirect_kind(redirect_kind),
    .trap_vec_valid(trap_vec_valid), .load_pc(load_pc), .pcmux_sel(pcmux_sel),
    .imem_read(imem_read), .ir_load(ir_load), .if_valid(if_valid), .flush(flush)
  );

  localparam logic [15:0] BR_TARGET = 16'h3000;
  localparam logic [15:0] SR1_VAL   = 16'h1230;
  logic [15:0] trap_vec = 16'h0400;

  int n_checks = 0;
  int n_pass   = 0;

  // model: instruction parked for decode, waiting for trap vector, one pending redirect
  bit          m_hold = 1'b0, m_trap = 1'b0, m_pend_v = 1'b0;
  logic [1:0]  m_pend_kind = 2'b00;
  logic [15:0] m_pc = 16'h0000, tb_pc = 16'h0000;
  logic [6:0]  exp_v, act_v;

  function automatic logic [15:0] next_pc(input logic [1:0] sel, input logic [15:0] pc);
    case (sel)
      2'b00:   next_pc = pc + 16'd2;
      2'b01:   next_pc = BR_TARGET;
      2'b10:   next_pc = SR1_VAL;
      default: next_pc = trap_vec;
    endcase
  endfunction

  // s = {reset, resp, stall, redirect_req, kind[1:0], trap_vec_valid}
  task automatic step(input logic [6:0] s);
    bit rst, resp, stl, rreq, tvv, nr, ev, cons, nh, nt;
    bit e_load, e_read, e_ir, e_ifv;
    logic [1:0] rkind, ek, e_sel;
    rst = s[6]; resp = s[5]; stl = s[4]; rreq = s[3]; rkind = s[2:1]; tvv = s[0];
    reset = rst; imem_resp = resp; stall = stl; redirect_req = rreq;
    redirect_kind = lc3b_pcmux_sel'(rkind); trap_vec_valid = tvv;
    #4;
    nr = !rst && rreq && (rkind != 2'b00) && !m_pend_v && !m_trap;
    ev = m_pend_v || nr;
    ek = m_pend_v ? m_pend_kind : rkind;
    e_load = 1'b0; e_sel = 2'b00; e_read = 1'b0; e_ir = 1'b0; e_ifv = 1'b0;
    if (!rst) begin
      if (m_trap) begin
        if (tvv) begin e_load = 1'b1; e_sel = 2'b11; end
      end else if (!m_hold) begin
        e_read = 1'b1;
        if (resp && ev && ek != 2'b11) begin e_load = 1'b1; e_sel = ek; end
        else if (resp && !ev) begin e_ir = 1'b1; e_ifv = 1'b1; e_load = !stl; end
      end else begin
        e_ifv = !ev;
        if (ev && ek != 2'b11) begin e_load = 1'b1; e_sel = ek; end
        else if (!ev && !stl) e_load = 1'b1;
      end
    end
    exp_v = {e_load, e_sel, e_read, e_ir, e_ifv, nr};
    act_v = {load_pc, pcmux_sel, imem_read, ir_load, if_valid, flush};
    cons  = !rst && !m_trap && ev && (m_hold || resp);
    nh    = !m_trap && !cons && stl && (m_hold || resp);
    nt    = m_trap ? !tvv : (cons && ek == 2'b11);
    @(posedge clk);
    if (rst) begin
      m_hold = 1'b0; m_trap = 1'b0; m_pend_v = 1'b0; m_pc = 16'h0000; tb_pc = 16'h0000;
    end else begin
      if (e_load) m_pc = next_pc(e_sel, m_pc);
      if (act_v[6]) tb_pc = next_pc(act_v[5:4], tb_pc);
      m_hold = nh; m_trap = nt;
      if (cons) m_pend_v = 1'b0;
      else if (nr) begin m_pend_v = 1'b1; m_pend_kind = rkind; end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step({1'b1, 6'($urandom_range(0, 63))});
      n_checks++;
      if (act_v !== 7'b0) $display("FAIL reset_outs cycle %0d: got %b expected 0000000", i, act_v);
      else n_pass++;
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      step(7'b0100000);
      n_checks++;
      if (act_v !== exp_v) $display("FAIL zero_wait_outs cycle %0d: got %b expected %b", i, act_v, exp_v);
      else n_pass++;
      n_checks++;
      if (tb_pc !== 16'(2 * (i + 1))) $display("FAIL zero_wait_pc cycle %0d: got %h expected %h", i, tb_pc, 16'(2 * (i + 1)));
      else n_pass++;
    end
  endtask

  task automatic run_table(input string name, input logic [6:0] tbl [$]);
    foreach (tbl[i]) begin
      step(tbl[i]);
      n_checks++;
      if (act_v !== exp_v) $display("FAIL %s_outs step %0d: got %b expected %b", name, i, act_v, exp_v);
      else n_pass++;
      n_checks++;
      if (tb_pc !== m_pc) $display("FAIL %s_pc step %0d: got %h expected %h", name, i, tb_pc, m_pc);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    run_table("wait_states", '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000});
  endtask

  task automatic test_stall_hold();
    run_table("stall_hold", '{7'b0110000, 7'b0010000, 7'b0010000, 7'b0000000, 7'b0100000});
  endtask

  task automatic test_redirect_pending();
    run_table("redirect_pending", '{7'b0001010, 7'b0001100, 7'b0000000, 7'b0100000, 7'b0100000});
    n_checks++;
    if (tb_pc !== BR_TARGET + 16'd2) $display("FAIL redirect_target: got %h expected %h", tb_pc, BR_TARGET + 16'd2);
    else n_pass++;
  endtask

  task automatic test_trap();
    trap_vec = 16'h0400;
    run_table("trap", '{7'b0110000, 7'b0011110, 7'b0001010, 7'b0000000, 7'b0000001});
    n_checks++;
    if (tb_pc !== 16'h0400) $display("FAIL trap_vector_pc: got %h expected 0400", tb_pc);
    else n_pass++;
    run_table("trap_resume", '{7'b0100000});
  endtask

  task automatic test_reset_mid();
    run_table("reset_mid", '{7'b0001010, 7'b0000000, 7'b1000000, 7'b0100000});
    n_checks++;
    if (tb_pc !== 16'h0002) $display("FAIL reset_mid_restart_pc: got %h expected 0002", tb_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] s;
    for (int i = 0; i < 400; i++) begin
      s[6]   = ($urandom_range(0, 49) == 0);
      s[5]   = ($urandom_range(0, 1) == 1);
      s[4]   = ($urandom_range(0, 2) == 0);
      s[3]   = ($urandom_range(0, 5) == 0);
      s[2:1] = 2'($urandom_range(0, 3));
      s[0]   = ($urandom_range(0, 2) == 0);
      trap_vec = {15'($urandom_range(0, 32767)), 1'b0};
      step(s);
      n_checks++;
      if (act_v !== exp_v) $display("FAIL random_outs cycle %0d: got %b expected %b", i, act_v, exp_v);
      else n_pass++;
      n_checks++;
      if (tb_pc !== m_pc) $display("FAIL random_pc cycle %0d: got %h expected %h", i, tb_pc, m_pc);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; imem_resp = 1'b0; stall = 1'b0; redirect_req = 1'b0;
    redirect_kind = pcmux_pc_plus2; trap_vec_valid = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect_pending();
    test_trap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
# fetch_control

Sequencing controller for the LC-3b instruction-fetch stage. It drives the PC load enable and the 4-way PC mux select, issues instruction-memory reads, and holds the PC stable while a read is outstanding. It absorbs downstream stalls, accepts redirects (taken branch, JMP/JSRR, TRAP) from later stages, and squashes wrong-path fetches. It sits beside the fetch datapath (PC register, +2 incrementer, pcmux), between the instruction-memory port and the IF/ID pipeline register.

## Interface
Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_resp  in  1  instruction memory read complete; rdata valid this cycle
- stall  in  1  decode cannot accept an instruction this cycle
- redirect_req  in  1  one-cycle request to change fetch path
- redirect_kind  in  2  lc3b_pcmux_sel value: 01 branch target, 10 register (sr1), 11 trap vector; 00 = no redirect
- trap_vec_valid  in  1  trap vector word present on data-memory rdata this cycle
- load_pc  out  1  PC register load enable
- pcmux_sel  out  2  00 pc+2, 01 br_add_out, 10 sr1_out, 11 mem_rdata
- imem_read  out  1  instruction memory read strobe; address is PC
- ir_load  out  1  capture imem rdata into fetch instruction buffer
- if_valid  out  1  fetch buffer holds a valid, non-squashed instruction for decode
- flush  out  1  one-cycle pulse: kill younger in-flight instructions

## Operation
- States: FETCH, HOLD, TRAP_WAIT. Redirect-pending latch: pend_v, pend_kind[1:0].
- Effective redirect: erv = pend_v | (redirect_req & redirect_kind != 00); ekind = pend_v ? pend_kind : redirect_kind.
- Pending latch loads when redirect_req is accepted and not consumed this cycle. It clears when consumed. While pend_v=1, further redirect_req is ignored: first (oldest) wins.
- flush=1 in any cycle where redirect_req is accepted (valid kind, not ignored).
- FETCH: imem_read=1. PC must not change until imem_resp.
  - No resp: hold.
  - Resp & erv & ekind∈{01,10}: load_pc=1, pcmux_sel=ekind, ir_load=0, consume redirect, stay FETCH.
  - Resp & erv & ekind=11: go TRAP_WAIT, consume redirect, no PC load.
  - Resp & no redirect & ~stall: ir_load=1, load_pc=1, sel=00, stay FETCH.
  - Resp & no redirect & stall: ir_load=1, no PC load, go HOLD.
- HOLD: imem_read=0, if_valid=1.
  - erv kind 01/10: load_pc, sel=kind, if_valid=0, go FETCH.
  - erv kind 11: if_valid=0, go TRAP_WAIT.
  - ~stall: load_pc, sel=00, go FETCH.
  - Otherwise stay.
- TRAP_WAIT: imem_read=0, if_valid=0. redirect_req ignored, no flush. On trap_vec_valid: load_pc=1, sel=11, go FETCH.
- if_valid in FETCH = ir_load (resp, no redirect). Redirect outranks stall.
- pcmux_sel=00 whenever load_pc=0.

## Timing
- Outputs are Mealy: combinational from state, pend latch and inputs.
- Reset cycle: all outputs 0. Reset clears state to FETCH and pend_v to 0. imem_read=1 on the first cycle after reset deasserts.
- Reset mid-read or in TRAP_WAIT: state abandoned, pending redirect dropped, no load_pc.
- Zero-wait memory (resp same cycle as read): one instruction per cycle, PC advances every edge.
- Redirect latency: PC loads at the edge ending the cycle of imem_resp (FETCH) or the same cycle (HOLD). The next imem_read then uses the new PC.
- TRAP: PC = vector at the edge of the trap_vec_valid cycle. Fetch resumes next cycle.

## Structure
- lc3b_types gains the enum lc3b_pcmux_sel (pcmux_pc_plus2=00, pcmux_br=01, pcmux_sr1=10, pcmux_mdr=11) and the fetch state enum. redirect_kind and pcmux_sel use lc3b_pcmux_sel.
- Single module, no sub-modules. Instantiated alongside the fetch datapath in the top-level pipeline.

## Test plan
- Reset, then imem_resp every cycle, stall=0 -> load_pc=1, sel=00 each cycle; PC 0x0000,0x0002,0x0004; if_valid each cycle.
- imem_resp after 3 wait cycles -> imem_read high 4 cycles, load_pc only on resp cycle, PC unchanged before.
- Resp with stall=1 for 2 cycles -> HOLD, if_valid=1 held, imem_read=0; PC advances by 2 the cycle stall drops.
- redirect_req kind 01 two cycles before imem_resp -> flush pulse immediately, pend_v held; on resp load_pc sel=01, ir_load=0. A second redirect kind 10 while pending -> ignored, no flush.
- redirect kind 11 in HOLD, trap_vec_valid after 2 cycles with rdata=0x0400 -> load_pc sel=11, next imem_read at 0x0400. redirect_req during TRAP_WAIT -> no flush.
- reset asserted mid-wait with pending redirect -> outputs 0, pend cleared, fetch restarts without a redirect.
